// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
//
// Out-of-order issue queue for a single functional-unit port. Renamed
// micro-ops arrive from dispatch over a valid/ready handshake and are written
// to the lowest-index free slot. Each source tracks its own ready flag, which
// is set by result-tag wakeup broadcasts. Every cycle the oldest entry whose
// sources are all ready is presented on the iss_* port. Age is kept in an
// ENTRIES x ENTRIES matrix, so slot position carries no age meaning.
//
// Optional feature: define ISSUE_QUEUE_FLUSH_EN to add the 'flush' input,
// which empties the queue at a clk_en edge.
//
// Ports:
//   clk, async_rst      clock (rising edge), asynchronous active-high reset
//   clk_en              global advance enable; all state holds when low
//   flush               (ISSUE_QUEUE_FLUSH_EN only) invalidate every entry
//   disp_*              dispatch handshake and micro-op payload
//   wake_valid/wake_tag result-tag wakeup broadcast ports
//   iss_*               selected micro-op and issue handshake
//   count, full, empty  occupancy status
// ---------------------------------------------------------------------------
module issue_queue #(
    parameter int ENTRIES         = 16,
    parameter int NUM_SRCS        = 2,
    parameter int OPCODE_WIDTH    = 7,
    parameter int PHYS_COUNT      = 128,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
    parameter int WAKEUP_PORTS    = 2,
    parameter int CNT_WIDTH       = $clog2(ENTRIES + 1)
) (
    input  logic                       clk,
    input  logic                       async_rst,
    input  logic                       clk_en,
`ifdef ISSUE_QUEUE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OPCODE_WIDTH-1:0]    disp_opcode,
    input  logic [PHYS_ADDR_WIDTH-1:0] disp_dest_addr,
    input  logic [PHYS_ADDR_WIDTH-1:0] disp_src_addr  [NUM_SRCS],
    input  logic                       disp_src_valid [NUM_SRCS],
    input  logic                       disp_src_ready [NUM_SRCS],
    input  logic                       wake_valid     [WAKEUP_PORTS],
    input  logic [PHYS_ADDR_WIDTH-1:0] wake_tag       [WAKEUP_PORTS],
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OPCODE_WIDTH-1:0]    iss_opcode,
    output logic [PHYS_ADDR_WIDTH-1:0] iss_dest_addr,
    output logic [PHYS_ADDR_WIDTH-1:0] iss_src_addr   [NUM_SRCS],
    output logic [CNT_WIDTH-1:0]       count,
    output logic                       full,
    output logic                       empty
);

    // -----------------------------------------------------------------------
    // Optional flush
    // -----------------------------------------------------------------------
    logic flush_w;
`ifdef ISSUE_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // Control state: reset to a known value.
    logic [ENTRIES-1:0]   valid_q, valid_d;
    // older_q[i][j] = 1 means entry j is older than entry i.
    logic [ENTRIES-1:0]   older_q [ENTRIES];
    logic [ENTRIES-1:0]   older_d [ENTRIES];
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Payload state: only meaningful while the matching valid_q bit is set.
    logic [OPCODE_WIDTH-1:0]    opcode_q   [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] dest_q     [ENTRIES];
    logic [PHYS_ADDR_WIDTH-1:0] src_tag_q  [ENTRIES][NUM_SRCS];
    logic                       src_used_q [ENTRIES][NUM_SRCS];
    logic                       src_rdy_q  [ENTRIES][NUM_SRCS];
    logic                       src_rdy_d  [ENTRIES][NUM_SRCS];

    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] grant;
    logic [ENTRIES-1:0] alloc_oh;
    logic               accept;
    logic               issue_fire;
    logic               disp_hit [NUM_SRCS];

    // -----------------------------------------------------------------------
    // Status
    // -----------------------------------------------------------------------
    assign count      = count_q;
    assign full       = (count_q == CNT_WIDTH'(ENTRIES));
    assign empty      = (count_q == '0);
    // A same-cycle issue is deliberately not credited here.
    assign disp_ready = !full && clk_en;
    assign accept     = disp_valid && disp_ready && !flush_w;

    // -----------------------------------------------------------------------
    // Select: oldest entry whose used sources are all ready
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        cand  = '0;
        grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cand[i] = valid_q[i];
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (src_used_q[i][s] && !src_rdy_q[i][s]) begin
                    cand[i] = 1'b0;
                end
            end
        end
        // An entry wins when no other candidate is older than it.
        for (int i = 0; i < ENTRIES; i++) begin
            grant[i] = cand[i] && ((cand & older_q[i]) == '0);
        end
    end

    assign iss_valid  = (|cand) && clk_en && !flush_w;
    assign issue_fire = iss_valid && iss_ready;

    // Outputs are masked to zero whenever nothing is presented.
    always_comb begin
        iss_opcode    = '0;
        iss_dest_addr = '0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            iss_src_addr[s] = '0;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (iss_valid && grant[i]) begin
                iss_opcode    |= opcode_q[i];
                iss_dest_addr |= dest_q[i];
                for (int s = 0; s < NUM_SRCS; s++) begin
                    iss_src_addr[s] |= src_tag_q[i][s];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Allocation: lowest-index slot free before the edge
    // -----------------------------------------------------------------------
    always_comb begin
        alloc_oh = '0;
        // Walk downward so the lowest free index is the last one written.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Wakeup: resident sources and same-cycle bypass for dispatched sources
    // -----------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < NUM_SRCS; s++) begin
            disp_hit[s] = 1'b0;
            for (int w = 0; w < WAKEUP_PORTS; w++) begin
                if (wake_valid[w] && (wake_tag[w] == disp_src_addr[s])) begin
                    disp_hit[s] = 1'b1;
                end
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                src_rdy_d[i][s] = src_rdy_q[i][s];
                for (int w = 0; w < WAKEUP_PORTS; w++) begin
                    if (wake_valid[w] && (wake_tag[w] == src_tag_q[i][s])) begin
                        src_rdy_d[i][s] = 1'b1;
                    end
                end
                if (accept && alloc_oh[i]) begin
                    src_rdy_d[i][s] = disp_src_ready[s] || disp_hit[s];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next control state
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        older_d = older_q;
        count_d = count_q;
        if (flush_w) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (issue_fire) begin
                valid_d &= ~grant;
            end
            if (accept) begin
                valid_d |= alloc_oh;
                // New entry is younger than every entry valid before the edge;
                // nobody is younger than... nobody treats it as older.
                for (int i = 0; i < ENTRIES; i++) begin
                    older_d[i] = older_q[i] & ~alloc_oh;
                    if (alloc_oh[i]) begin
                        older_d[i] = valid_q;
                    end
                end
            end
            count_d = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(issue_fire);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= '0;
            end
        end else if (clk_en) begin
            valid_q <= valid_d;
            older_q <= older_d;
            count_q <= count_d;
        end
    end

    // NOTE: the payload array has no reset; every read of it is qualified by
    // valid_q, which is reset, so clearing it would only add reset fanout.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int s = 0; s < NUM_SRCS; s++) begin
                    src_rdy_q[i][s] <= src_rdy_d[i][s];
                end
                if (accept && alloc_oh[i]) begin
                    opcode_q[i] <= disp_opcode;
                    dest_q[i]   <= disp_dest_addr;
                    for (int s = 0; s < NUM_SRCS; s++) begin
                        src_tag_q[i][s]  <= disp_src_addr[s];
                        src_used_q[i][s] <= disp_src_valid[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_issue_queue
//
// Self-checking bench for issue_queue. A reference model keeps the resident
// micro-ops in a queue ordered by dispatch time: the oldest fully ready one
// is the expected issue, and wakeups/dispatches/issues are applied at each
// clk_en edge. Directed scenarios run first, then randomized traffic with a
// mid-run asynchronous reset.
// ---------------------------------------------------------------------------
module tb_issue_queue;

    localparam int ENTRIES = 16;
    localparam int NSRC    = 2;
    localparam int OPW     = 7;
    localparam int TW      = 7;
    localparam int WP      = 2;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          clk_en;
    logic          flush;
    logic          disp_valid;
    logic          disp_ready;
    logic [OPW-1:0] disp_opcode;
    logic [TW-1:0] disp_dest_addr;
    logic [TW-1:0] disp_src_addr  [NSRC];
    logic          disp_src_valid [NSRC];
    logic          disp_src_ready [NSRC];
    logic          wake_valid     [WP];
    logic [TW-1:0] wake_tag       [WP];
    logic          iss_valid;
    logic          iss_ready;
    logic [OPW-1:0] iss_opcode;
    logic [TW-1:0] iss_dest_addr;
    logic [TW-1:0] iss_src_addr   [NSRC];
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    issue_queue #(
        .ENTRIES(ENTRIES), .NUM_SRCS(NSRC), .OPCODE_WIDTH(OPW),
        .PHYS_COUNT(128), .PHYS_ADDR_WIDTH(TW), .WAKEUP_PORTS(WP),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .async_rst(async_rst),
        .clk_en(clk_en),
`ifdef ISSUE_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .disp_opcode(disp_opcode),
        .disp_dest_addr(disp_dest_addr),
        .disp_src_addr(disp_src_addr),
        .disp_src_valid(disp_src_valid),
        .disp_src_ready(disp_src_ready),
        .wake_valid(wake_valid),
        .wake_tag(wake_tag),
        .iss_valid(iss_valid),
        .iss_ready(iss_ready),
        .iss_opcode(iss_opcode),
        .iss_dest_addr(iss_dest_addr),
        .iss_src_addr(iss_src_addr),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [OPW-1:0]           op;
        logic [TW-1:0]            dest;
        logic [NSRC-1:0][TW-1:0]  tag;
        logic [NSRC-1:0]          rdy;   // unused sources are held ready
    } uop_t;

    uop_t mq[$];   // index 0 is the oldest resident micro-op
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit woken(input logic [TW-1:0] t);
        for (int w = 0; w < WP; w++) begin
            if (wake_valid[w] && wake_tag[w] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called just after a negedge with inputs already driven: compares every
    // output against the model, advances the model by one edge, then waits
    // for the next negedge.
    task automatic step();
        int   sel;
        bit   iv;
        bit   acc;
        uop_t u;
        uop_t n;
        #1;
        sel = -1;
        foreach (mq[i]) begin
            if (sel < 0 && (&mq[i].rdy)) sel = i;
        end
        iv = (sel >= 0) && clk_en && !flush;
        u  = '0;
        if (iv) u = mq[sel];
        check("iss_valid",  32'(iss_valid), 32'(iv));
        check("iss_opcode", 32'(iss_opcode), 32'(u.op));
        check("iss_dest",   32'(iss_dest_addr), 32'(u.dest));
        check("iss_src0",   32'(iss_src_addr[0]), 32'(u.tag[0]));
        check("iss_src1",   32'(iss_src_addr[1]), 32'(u.tag[1]));
        check("count",      32'(count), 32'(mq.size()));
        check("full",       32'(full), 32'(mq.size() == ENTRIES));
        check("empty",      32'(empty), 32'(mq.size() == 0));
        check("disp_ready", 32'(disp_ready), 32'((mq.size() < ENTRIES) && clk_en));

        if (clk_en) begin
            acc = disp_valid && (mq.size() < ENTRIES) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (iv && iss_ready) mq.delete(sel);
                foreach (mq[i]) begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (woken(mq[i].tag[s])) mq[i].rdy[s] = 1'b1;
                    end
                end
                if (acc) begin
                    n.op   = disp_opcode;
                    n.dest = disp_dest_addr;
                    for (int s = 0; s < NSRC; s++) begin
                        n.tag[s] = disp_src_addr[s];
                        n.rdy[s] = !disp_src_valid[s] || disp_src_ready[s] ||
                                   woken(disp_src_addr[s]);
                    end
                    mq.push_back(n);
                end
            end
        end
        @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic idle();
        clk_en         = 1'b1;
        flush          = 1'b0;
        disp_valid     = 1'b0;
        disp_opcode    = '0;
        disp_dest_addr = '0;
        for (int s = 0; s < NSRC; s++) begin
            disp_src_addr[s]  = '0;
            disp_src_valid[s] = 1'b0;
            disp_src_ready[s] = 1'b0;
        end
        for (int w = 0; w < WP; w++) begin
            wake_valid[w] = 1'b0;
            wake_tag[w]   = '0;
        end
        iss_ready = 1'b0;
    endtask

    // Offer an op using only source 0; destination mirrors the opcode.
    task automatic offer(input logic [OPW-1:0] op, input logic [TW-1:0] t0, input logic r0);
        disp_valid        = 1'b1;
        disp_opcode       = op;
        disp_dest_addr    = TW'(op) ^ 7'h7f;
        disp_src_addr[0]  = t0;
        disp_src_valid[0] = 1'b1;
        disp_src_ready[0] = r0;
        disp_src_addr[1]  = t0 + 7'd1;
        disp_src_valid[1] = 1'b0;
        disp_src_ready[1] = 1'b0;
    endtask

    task automatic wake(input int port, input logic [TW-1:0] t);
        wake_valid[port] = 1'b1;
        wake_tag[port]   = t;
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        idle();
        async_rst = 1'b1;
        #12;
        check("rst_count",  32'(count), 32'd0);
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_full",   32'(full), 32'd0);
        check("rst_iss_v",  32'(iss_valid), 32'd0);
        check("rst_dready", 32'(disp_ready), 32'd1);
        clk_en = 1'b0;
        #1;
        check("rst_dready_noen", 32'(disp_ready), 32'd0);
        clk_en = 1'b1;
        @(negedge clk);
        async_rst = 1'b0;

        // In-order issue of three ready ops.
        iss_ready = 1'b1;
        offer(7'h11, 7'd1, 1'b1); step();
        offer(7'h22, 7'd2, 1'b1); step();
        offer(7'h33, 7'd3, 1'b1); step();
        disp_valid = 1'b0;
        repeat (4) step();

        // A waits on tag 5, B is ready: B first, A after the wakeup.
        idle(); iss_ready = 1'b1;
        offer(7'h0a, 7'd5, 1'b0); step();
        offer(7'h0b, 7'd6, 1'b1); step();
        disp_valid = 1'b0;
        repeat (2) step();
        wake(0, 7'd5); step();
        wake_valid[0] = 1'b0;
        repeat (3) step();

        // Same-cycle wakeup bypass on dispatch.
        idle(); iss_ready = 1'b1;
        offer(7'h0c, 7'd9, 1'b0);
        wake(1, 7'd9);
        step();
        idle(); iss_ready = 1'b1;
        repeat (2) step();

        // Fill with unready ops, hold an extra offer, free one slot.
        idle();
        for (int i = 0; i < ENTRIES; i++) begin
            offer(OPW'(7'h40 + i), TW'(100 + i), 1'b0);
            step();
        end
        offer(7'h60, 7'd116, 1'b0);
        repeat (2) step();
        wake(0, 7'd100); step();
        wake_valid[0] = 1'b0;
        iss_ready = 1'b1;
        step();
        step();
        disp_valid = 1'b0;
        for (int t = 101; t <= 116; t++) begin
            wake(0, TW'(t)); step();
            wake_valid[0] = 1'b0; step();
        end

        // clk_en low freezes everything.
        idle();
        offer(7'h51, 7'd1, 1'b1); step();
        offer(7'h52, 7'd2, 1'b1); step();
        offer(7'h53, 7'd3, 1'b1);
        clk_en = 1'b0; iss_ready = 1'b1;
        repeat (3) step();
        clk_en = 1'b1; disp_valid = 1'b0;
        repeat (4) step();

`ifdef ISSUE_QUEUE_FLUSH_EN
        // Flush with four resident entries.
        idle();
        for (int i = 0; i < 4; i++) begin
            offer(OPW'(7'h70 + i), TW'(i), 1'b1);
            step();
        end
        offer(7'h7f, 7'd8, 1'b1);
        flush = 1'b1; iss_ready = 1'b1;
        step();
        flush = 1'b0; disp_valid = 1'b0;
        repeat (2) step();
`endif

        // Randomized traffic with an asynchronous reset part way through.
        for (int c = 0; c < 3000; c++) begin
            clk_en         = ($urandom_range(9) != 0);
`ifdef ISSUE_QUEUE_FLUSH_EN
            flush          = ($urandom_range(49) == 0);
`else
            flush          = 1'b0;
`endif
            disp_valid     = ($urandom_range(2) != 0);
            disp_opcode    = OPW'($urandom);
            disp_dest_addr = TW'($urandom);
            for (int s = 0; s < NSRC; s++) begin
                disp_src_addr[s]  = TW'($urandom_range(15));
                disp_src_valid[s] = ($urandom_range(1) != 0);
                disp_src_ready[s] = ($urandom_range(3) == 0);
            end
            for (int w = 0; w < WP; w++) begin
                wake_valid[w] = ($urandom_range(1) != 0);
                wake_tag[w]   = TW'($urandom_range(15));
            end
            iss_ready = ($urandom_range(3) != 0);
            if (c == 1500) begin
                clk_en    = 1'b1;
                async_rst = 1'b1;
                #1;
                check("midrst_count", 32'(count), 32'd0);
                check("midrst_empty", 32'(empty), 32'd1);
                check("midrst_iss_v", 32'(iss_valid), 32'd0);
                mq.delete();
                #1;
                async_rst = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised out-of-order issue queue that succeeds the flat indexed instruction store. It accepts renamed micro-ops from dispatch through a valid/ready handshake and tracks per-source readiness against result-tag wakeup broadcasts. Each cycle it selects the oldest fully ready entry for a single functional-unit port. It sits between rename/dispatch and the execute stage, and owns slot allocation internally, so callers never supply queue addresses.

## Interface
- `ENTRIES`, default 16: queue depth, ≥2.
- `NUM_SRCS`, default 2: source operands per entry, 1–3.
- `OPCODE_WIDTH`, default 7: opcode field width.
- `PHYS_COUNT`, default 128: physical register count.
- `PHYS_ADDR_WIDTH`, default $clog2(PHYS_COUNT): physical tag width.
- `WAKEUP_PORTS`, default 2: number of result-tag broadcast ports.
- `CNT_WIDTH`, default $clog2(ENTRIES+1): occupancy count width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `async_rst` in 1: asynchronous, active-high reset.
- `clk_en` in 1: global advance enable; state holds when low.
- `disp_valid` in 1: dispatch offers a micro-op.
- `disp_ready` out 1: queue can accept.
- `disp_opcode` in OPCODE_WIDTH: opcode.
- `disp_dest_addr` in PHYS_ADDR_WIDTH: destination tag.
- `disp_src_addr[NUM_SRCS]` in PHYS_ADDR_WIDTH each: source tags.
- `disp_src_valid[NUM_SRCS]` in 1 each: source is used.
- `disp_src_ready[NUM_SRCS]` in 1 each: source already available at dispatch.
- `wake_valid[WAKEUP_PORTS]` in 1 each: broadcast valid.
- `wake_tag[WAKEUP_PORTS]` in PHYS_ADDR_WIDTH each: produced tag.
- `iss_valid` out 1: a ready entry is presented.
- `iss_ready` in 1: functional unit accepts.
- `iss_opcode` out OPCODE_WIDTH: selected opcode.
- `iss_dest_addr` out PHYS_ADDR_WIDTH: selected destination.
- `iss_src_addr[NUM_SRCS]` out PHYS_ADDR_WIDTH each: selected source tags.
- `count` out CNT_WIDTH: occupied entries.
- `full` out 1: count == ENTRIES.
- `empty` out 1: count == 0.

## Operation
- Each entry holds: valid, opcode, dest, and per source the tag, used flag and ready flag.
- An unused source (`disp_src_valid`=0) counts as ready.
- **Allocation:** a dispatch is accepted when `disp_valid && disp_ready && clk_en`. It is written to the lowest-index free entry.
- **Age:** an ENTRIES×ENTRIES age matrix is kept. On allocation, the new entry is marked younger than every currently valid entry.
- **Wakeup:** on each `clk_en` edge, every valid entry source whose tag equals any valid `wake_tag` sets its ready flag. Ready flags never clear while the entry is valid.
- **Same-cycle wakeup bypass:** a source being dispatched is written ready if `disp_src_ready` is set, or if its tag matches any `wake_tag` with `wake_valid` set in that cycle.
- **Select:** combinational from registered state. A candidate is a valid entry with all sources ready. The oldest candidate per the age matrix drives `iss_*`. `iss_valid` = any candidate && `clk_en`.
- **Issue:** when `iss_valid && iss_ready`, the selected entry is invalidated at the edge. Its age row and column become don't-care.
- **Count:** count updates by +accept −issue at each edge. Simultaneous accept and issue leave it unchanged.
- `disp_ready` = !full && `clk_en`. It does not credit a same-cycle issue.
- Tag width mismatch is impossible by construction. No duplicate-tag checking is performed.

## Timing
- Reset values:
  - all entries invalid, age matrix zero;
  - `count`=0, `empty`=1, `full`=0;
  - `disp_ready`=1 when `clk_en`=1, otherwise 0;
  - `iss_valid`=0;
  - `iss_opcode`, `iss_dest_addr` and `iss_src_addr` = 0 while `iss_valid`=0 (outputs are masked).
- Dispatch-to-issue latency: an entry dispatched with all sources ready may issue in the cycle after acceptance, never in the same cycle.
- Wakeup-to-issue latency: a wakeup at edge N makes the entry eligible during cycle N+1.
- Full: the dispatch offer is not taken, `disp_ready`=0 and the micro-op stays at the input. An issue in the same cycle frees a slot for the next cycle.
- Empty: `iss_valid`=0, and the `iss_*` fields are 0.
- Simultaneous dispatch into the slot being freed in the same cycle is not allowed. Allocation uses pre-edge free state, so a just-freed slot becomes allocatable next cycle.
- `clk_en`=0: no writes, no wakeups latched, no issue. Wakeup broadcasts in that cycle are lost, so the producer must hold `wake_valid` until `clk_en`.
- `async_rst` mid-operation clears all state immediately. Outputs take their reset values without waiting for a clock edge.

## Configuration
- Macro `ISSUE_QUEUE_FLUSH_EN`.
- **Defined:** adds input port `flush` (1 bit). With `flush`=1 at a `clk_en` edge, all entries are invalidated and `count` goes to 0. A dispatch or issue in that cycle is discarded and `iss_valid` is forced 0 in that cycle.
- **Undefined:** no `flush` port. Entries leave the queue only by issue or reset.

## Test plan
- Reset, then dispatch 3 ops with all sources ready (opcodes 0x11, 0x22, 0x33), `iss_ready`=1 -> issued in order 0x11, 0x22, 0x33 on consecutive cycles. First issue comes one cycle after the first accept, and `count` returns to 0.
- Dispatch op A waiting on tag 5, then op B fully ready. Wake tag 5 two cycles later -> B issues first, and A issues in the cycle after the wakeup edge.
- Dispatch with `disp_src_addr[0]`=9 while `wake_tag[1]`=9 is valid in the same cycle -> entry is issue-eligible the next cycle.
- Fill ENTRIES ops with unready sources -> `full`=1, `disp_ready`=0. A further offer is held, then accepted one cycle after a single issue.
- `clk_en`=0 for 3 cycles with ready entries and `iss_ready`=1 -> no issue, `count` unchanged, `disp_ready`=0.
- With `ISSUE_QUEUE_FLUSH_EN`: 4 entries valid, pulse `flush` -> `count`=0, `empty`=1, and `iss_valid`=0 the following cycle.
